// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states,
// byte-enable width.
package load_store_unit_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_load_align: byte-lane steering.
// STORE=0: pull the addressed byte/half down to bit 0 and sign/zero extend.
// STORE=1: the reverse, push the low byte/half of the data up into its lane.
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter bit STORE = 1'b0
) (
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  if (STORE) begin : g_st
    // Shift the store operand left into the lane selected by the offset.
    always_comb begin
      result = '0;
      case (funct3)
        F3_B:    result = {24'b0, rdata[7:0]} << {offset, 3'b000};
        F3_H:    result = {16'b0, rdata[15:0]} << {offset, 3'b000};
        F3_W:    result = rdata;
        default: result = '0;
      endcase
    end
  end else begin : g_ld
    logic [31:0] sh;
    assign sh = rdata >> {offset, 3'b000};

    // Select the lane and extend it to 32 bits.
    always_comb begin
      result = '0;
      case (funct3)
        F3_B:    result = {{24{sh[7]}}, sh[7:0]};
        F3_H:    result = {{16{sh[15]}}, sh[15:0]};
        F3_W:    result = sh;
        F3_BU:   result = {24'b0, sh[7:0]};
        F3_HU:   result = {16'b0, sh[15:0]};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store sequencer
// (IDLE -> WAIT -> DONE) with a bounded wait for the memory ack.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete
// immediately with misalign=1 instead of being aligned down.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      funct3,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic            stall,
  output logic [31:0]     rd_data,
  output logic            done,
  output logic            bus_err,
  output logic            misalign,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e          state_q, state_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [BE_W-1:0] be_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q, mis_q;
  logic [31:0]     rd_q;

  logic            accept, illegal, trap, is_h, is_w, timeout;
  logic [31:0]     eff_addr, st_data, ld_data;
  logic [BE_W-1:0] be_d;

  assign accept  = (state_q == IDLE) & req_valid;
  assign illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (funct3[2] & req_we);
  assign is_h    = (funct3[1:0] == 2'b01);
  assign is_w    = (funct3 == F3_W);
  assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (is_h & addr[0]) | (is_w & (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Halves drop addr[0], words drop addr[1:0]; with the trap enabled a
  // misaligned access never issues, so this only matters when it is off.
  assign eff_addr = {addr[31:2], (is_w ? 2'b00 : {addr[1], addr[0] & ~is_h})};

  lsu_load_align #(.STORE(1'b1)) u_st_lane (
    .rdata  (wdata),
    .offset (eff_addr[1:0]),
    .funct3 (funct3),
    .result (st_data)
  );

  lsu_load_align #(.STORE(1'b0)) u_ld_lane (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .result (ld_data)
  );

  // Byte enables for the access being accepted; loads always read the word.
  always_comb begin
    be_d = 4'b1111;
    if (req_we) begin
      case (funct3)
        F3_B:    be_d = 4'b0001 << eff_addr[1:0];
        F3_H:    be_d = 4'b0011 << eff_addr[1:0];
        default: be_d = 4'b1111;
      endcase
    end
  end

  // Next-state logic; illegal or trapped requests bypass WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (illegal | trap) ? DONE : WAIT;
      WAIT: if (mem_ack | timeout) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset drops mem_req at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, wait counter and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= funct3;
      addr_q  <= eff_addr;
      wdata_q <= st_data;
      be_q    <= be_d;
      cnt_q   <= '0;
      err_q   <= illegal;
      mis_q   <= trap & ~illegal;
    end else if (state_q == WAIT) begin
      if (mem_ack) begin
        // ack wins over a simultaneous timeout
        if (!we_q) rd_q <= ld_data;
      end else if (timeout) begin
        err_q <= 1'b1;
        rd_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stall     = accept | (state_q == WAIT);
  assign done      = (state_q == DONE);
  assign bus_err   = done & err_q;
  assign misalign  = done & mis_q;
  assign rd_data   = rd_q;
  assign mem_req   = (state_q == WAIT);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYC=4. Inputs are driven
// and outputs sampled on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, done, bus_err, misalign;
  logic [31:0] rd_data;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rd_data   (rd_data),
    .done      (done),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = d;
  endtask

  // Load acked on the first WAIT cycle; checks the result in DONE.
  task automatic load_ack(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    @(negedge clk); issue(1'b0, f3, a, 32'h0);
    @(negedge clk); req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk); mem_ack = 1'b0;
    #1 chk(tag, rd_data, exp);
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int  hi;
    bit  got;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be",  32'(mem_be),  32'd0);
    chk("rst_mem_addr", mem_addr,    32'd0);
    chk("rst_rd_data",  rd_data,     32'd0);
    chk("rst_flags", 32'({done, bus_err, misalign, stall}), 32'd0);
    rst_n = 1'b1;

    // LB 0x103, byte 0x80 -> sign extended
    @(negedge clk); issue(1'b0, 3'b000, 32'h103, 32'h0);
    #1 chk("lb_stall_n", 32'(stall), 32'd1);
    @(negedge clk); req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    #1;
    chk("lb_mem_req", 32'(mem_req), 32'd1);
    chk("lb_stall_n1", 32'(stall), 32'd1);
    chk("lb_mem_addr", mem_addr, 32'h100);
    chk("lb_mem_be", 32'(mem_be), 32'hF);
    @(negedge clk); mem_ack = 1'b0;
    #1;
    chk("lb_done", 32'(done), 32'd1);
    chk("lb_rd", rd_data, 32'hFFFF_FF80);
    chk("lb_stall_done", 32'(stall), 32'd0);
    chk("lb_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    #1 chk("lb_done_pulse", 32'(done), 32'd0);

    // SH 0x202
    @(negedge clk); issue(1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("sh_mem_be", 32'(mem_be), 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'hABCD_0000);
    chk("sh_mem_addr", mem_addr, 32'h200);
    chk("sh_mem_we", 32'(mem_we), 32'd1);
    @(negedge clk); mem_ack = 1'b1;
    #1;
    chk("sh_hold_req", 32'(mem_req), 32'd1);
    chk("sh_hold_be", 32'(mem_be), 32'hC);
    @(negedge clk); mem_ack = 1'b0;
    #1;
    chk("sh_done", 32'(done), 32'd1);
    chk("sh_rd_kept", rd_data, 32'hFFFF_FF80);

    // other load sizes
    load_ack("lh",  3'b001, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
    load_ack("lhu", 3'b101, 32'h100, 32'h1234_F00D, 32'h0000_F00D);
    load_ack("lbu", 3'b100, 32'h101, 32'h0000_9A00, 32'h0000_009A);
    load_ack("lw",  3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // LW timeout: 4 cycles of mem_req, then bus_err with rd_data cleared
    @(negedge clk); issue(1'b0, 3'b010, 32'h300, 32'h0);
    hi = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); req_valid = 1'b0;
      #1;
      if (mem_req) hi++;
      if (done) begin
        got = 1'b1;
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_rd_zero", rd_data, 32'd0);
      end
    end
    chk("to_req_cycles", 32'(hi), 32'd4);
    chk("to_done_seen", 32'(got), 32'd1);

    // ack on the last allowed WAIT cycle wins
    @(negedge clk); issue(1'b0, 3'b010, 32'h400, 32'h0);
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hCAFE_BABE;
    #1 chk("aw_req_last", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ack = 1'b0;
    #1;
    chk("aw_done", 32'(done), 32'd1);
    chk("aw_no_err", 32'(bus_err), 32'd0);
    chk("aw_rd", rd_data, 32'hCAFE_BABE);

    // illegal funct3 on a load, and BU on a store
    @(negedge clk); issue(1'b0, 3'b011, 32'h10, 32'h0);
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("ill_ld_req", 32'(mem_req), 32'd0);
    chk("ill_ld_done_err", 32'({done, bus_err}), 32'd3);
    @(negedge clk); issue(1'b1, 3'b100, 32'h10, 32'h55);
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("ill_st_req", 32'(mem_req), 32'd0);
    chk("ill_st_done_err", 32'({done, bus_err}), 32'd3);

    // misaligned LW 0x101
    @(negedge clk); issue(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_done_flag", 32'({done, misalign, bus_err}), 32'b110);
    chk("mis_rd_kept", rd_data, 32'hCAFE_BABE);
`else
    @(negedge clk); req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    #1;
    chk("mis_addr_down", mem_addr, 32'h100);
    chk("mis_req", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ack = 1'b0;
    #1;
    chk("mis_done_flag", 32'({done, misalign, bus_err}), 32'b100);
    chk("mis_rd", rd_data, 32'h1122_3344);
`endif

    // reset on the 2nd WAIT cycle of an LHU, late ack afterwards
    @(negedge clk);
    @(negedge clk); issue(1'b0, 3'b101, 32'h500, 32'h0);
    @(negedge clk); req_valid = 1'b0;
    #1 chk("rw_req_w1", 32'(mem_req), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rw_req_drop", 32'(mem_req), 32'd0);
    chk("rw_rd_zero", rd_data, 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rw_no_done", 32'({done, bus_err}), 32'd0);
      chk("rw_no_req", 32'(mem_req), 32'd0);
      chk("rw_rd_hold", rd_data, 32'd0);
    end
    mem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255; maximum cycles spent in WAIT before the access is aborted.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  EX stage presents a load or store this cycle.
REQ-005 Port: req_we  input  1  1 = store, 0 = load.
REQ-006 Port: funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
REQ-007 Port: addr  input  32  byte address (ALU result).
REQ-008 Port: wdata  input  32  store data (rs2).
REQ-009 Port: stall  output  1  freezes the pipeline while an access is in flight.
REQ-010 Port: rd_data  output  32  aligned, extended load result; feeds the "RD mem" leg of the writeback mux.
REQ-011 Port: done  output  1  one-cycle pulse when the access completes.
REQ-012 Port: bus_err  output  1  one-cycle pulse with done on timeout or illegal funct3.
REQ-013 Port: misalign  output  1  one-cycle pulse with done on a misaligned access.
REQ-014 Ports to memory: mem_req o1, mem_we o1, mem_be o4, mem_addr o32 (bits [1:0] = 0), mem_wdata o32, mem_ack i1, mem_rdata i32.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and DONE.
REQ-016 IDLE: when req_valid = 1, the unit SHALL latch req_we, funct3, addr and wdata and go to WAIT; mem_req SHALL assert from the next cycle.
REQ-017 WAIT: mem_req and all mem_* outputs SHALL be held stable until mem_ack = 1; on mem_ack = 1 the unit SHALL go to DONE.
REQ-018 DONE: done = 1 for exactly one cycle; mem_req = 0; the next state SHALL be IDLE (no back-to-back accept from DONE).
REQ-019 stall = (IDLE & req_valid) | WAIT; stall = 0 in DONE so the pipeline advances.
REQ-020 Minimum latency: request at cycle N, mem_req at N+1; an ack at N+1 gives DONE and valid rd_data at N+2.
REQ-021 Stores: mem_be = 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, 1111 for W; wdata is replicated into the selected lanes; mem_we = 1.
REQ-022 Loads: the selected byte or half of mem_rdata SHALL be registered into rd_data at ack, sign-extended for B/H and zero-extended for BU/HU; mem_be = 1111.
REQ-023 rd_data SHALL hold its value until the next load completes; stores SHALL NOT change it.
REQ-024 A wait counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYC without an ack, the unit SHALL drop mem_req, go to DONE and assert bus_err, with rd_data = 0.
REQ-025 An ack arriving in the same cycle the counter reaches TIMEOUT_CYC SHALL win (normal completion, no bus_err).
REQ-026 Illegal funct3 (011, 110, 111, or BU/HU with req_we = 1) SHALL skip WAIT, issue no mem_req, and assert bus_err in DONE.

Reset
REQ-027 While rst_n = 0: state = IDLE, mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, rd_data = 0, done = bus_err = misalign = 0, wait counter = 0.
REQ-028 A reset asserted mid-WAIT SHALL drop mem_req immediately (asynchronously); the access is abandoned and a late mem_ack after reset SHALL be ignored.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: an H access with addr[0] = 1, or a W access with addr[1:0] != 0, SHALL issue no memory access and SHALL go IDLE->DONE with misalign = 1; loads leave rd_data unchanged.
REQ-030 Macro undefined: misalign is tied to 0, and misaligned addresses are aligned down (H: addr[0] forced to 0; W: addr[1:0] forced to 0) before issue.

Structure
REQ-031 A shared package SHALL hold the funct3 encodings, the FSM state enum (IDLE/WAIT/DONE) and the byte-enable width constant.
REQ-032 Lane alignment and extension SHALL live in one combinational sub-module, lsu_load_align (inputs: rdata, offset, funct3; output: 32-bit result), reused for store lane replication in reverse.

Verification
REQ-033 LB at addr 0x103, mem_rdata 0x80FF_1234, ack on the first WAIT cycle -> rd_data = 0xFFFF_FF80 at N+2, done = 1, stall = 1 for cycles N and N+1.
REQ-034 SH at addr 0x202, wdata 0x0000_ABCD -> mem_be = 1100, mem_wdata[31:16] = 0xABCD, mem_addr = 0x200, mem_we = 1.
REQ-035 LW with mem_ack never asserted, TIMEOUT_CYC = 4 -> mem_req high for 4 cycles, then done = bus_err = 1, rd_data = 0.
REQ-036 LW at addr 0x101 -> with LSU_MISALIGN_TRAP_EN: misalign = 1, no mem_req; without it: mem_addr = 0x100, misalign = 0.
REQ-037 rst_n pulled low on the 2nd WAIT cycle of an LHU, then mem_ack arrives after release -> mem_req = 0 immediately, state IDLE, rd_data = 0, no done.
